// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Request address width, lock FSM states and read-owner codes.
package imem_arbiter_pkg;

  localparam int unsigned REG_SIZE = 32;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_DRAIN,
    ST_LOCKED
  } state_t;

  typedef enum logic {
    OWN_F,
    OWN_D
  } owner_t;

endpackage

// File: rtl/imem_tag_pipe.sv
// Valid/owner shift register matching the BRAM read latency.
// f_pending flags fetch reads that will still be in flight after this cycle.
module imem_tag_pipe
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_t in_owner,
  output logic   out_valid,
  output owner_t out_owner,
  output logic   f_pending
);

  logic [DEPTH-1:0] vld;
  owner_t           own [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) own[i] <= OWN_D;
    end else begin
      vld[0] <= in_valid;
      own[0] <= in_owner;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        own[i] <= own[i-1];
      end
    end
  end

  // The output stage is delivered this cycle, so it does not hold off the lock.
  always_comb begin
    f_pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (vld[i] && own[i] == OWN_F) f_pending = 1'b1;
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_owner = own[DEPTH-1];

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction BRAM port between CPU fetch and the debug/loader port,
// with round-robin arbitration and a lock mode that drains and holds off fetch.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [REG_SIZE-1:0] f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [REG_SIZE-1:0] d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                locked,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  state_t            state, state_nxt;
  owner_t            last_win;
  logic [ADDR_W-1:0] addr_q;
  logic              p_valid, f_pending;
  owner_t            p_owner;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{f_addr[REG_SIZE-1:ADDR_W], d_addr[REG_SIZE-1:ADDR_W]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_NORMAL;
      last_win <= OWN_D;
      addr_q   <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= m_addr;
      if (f_gnt)      last_win <= OWN_F;
      else if (d_gnt) last_win <= OWN_D;
    end
  end

  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (f_req && d_req) begin
          f_gnt = (last_win == OWN_D);
          d_gnt = (last_win == OWN_F);
        end else begin
          f_gnt = f_req;
          d_gnt = d_req;
        end
        if (d_lock) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        d_gnt = d_req;
        if (!d_lock)         state_nxt = ST_NORMAL;
        else if (!f_pending) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        d_gnt = d_req;
        if (!d_lock) state_nxt = ST_NORMAL;
      end
      default: state_nxt = ST_NORMAL;
    endcase
    if (!reset) begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // Address is held from the last grant so the BRAM port stays quiet when idle.
  assign m_addr  = f_gnt ? f_addr[ADDR_W-1:0] : (d_gnt ? d_addr[ADDR_W-1:0] : addr_q);
  assign m_we    = d_gnt & d_we;
  assign m_wdata = d_wdata;

  imem_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (f_gnt | (d_gnt & ~d_we)),
    .in_owner  (f_gnt ? OWN_F : OWN_D),
    .out_valid (p_valid),
    .out_owner (p_owner),
    .f_pending (f_pending)
  );

  // Gated by reset so a read completing in the reset cycle is dropped, not returned.
  assign f_rvalid = reset & p_valid & (p_owner == OWN_F);
  assign d_rvalid = reset & p_valid & (p_owner == OWN_D);
  assign f_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign locked   = (state == ST_LOCKED);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: stimulus pushes expected read returns into a
// queue, and a separate monitor pops and compares on every rvalid.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned READ_LAT = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                f_req, f_gnt, f_rvalid;
  logic [REG_SIZE-1:0] f_addr;
  logic [DATA_W-1:0]   f_rdata;
  logic                d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [REG_SIZE-1:0] d_addr;
  logic [DATA_W-1:0]   d_wdata, d_rdata;
  logic                locked, m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata, m_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .locked(locked), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // BRAM model: unwritten words read back as a fixed pattern of their address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  logic [31:0] mem [1024];
  bit [1023:0] wr_seen = '0;

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_addr]     <= m_wdata;
      wr_seen[m_addr] <= 1'b1;
    end
    m_rdata <= wr_seen[m_addr] ? mem[m_addr] : init_word({22'b0, m_addr});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dd, input logic dl);
    @(posedge clk);
    #1;
    reset = rst; f_req = fr; f_addr = fa;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    #2;
  endtask

  task automatic gnt(input string name, input logic fg, input logic dg);
    chk({name, "_fgnt"}, {31'b0, f_gnt}, {31'b0, fg});
    chk({name, "_dgnt"}, {31'b0, d_gnt}, {31'b0, dg});
  endtask

  task automatic push_f(input logic [31:0] data); exp_q.push_back({1'b0, data}); endtask
  task automatic push_d(input logic [31:0] data); exp_q.push_back({1'b1, data}); endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: every rvalid must match the oldest expected return.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (f_rvalid && d_rvalid) begin
        n_checks++; n_fail++;
        $display("FAIL dual_rvalid: got both rvalids, required at most one");
      end else if (f_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rvalid: got f=%0b d=%0b data %h, required none",
                   f_rvalid, d_rvalid, m_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", {31'b0, d_rvalid}, {31'b0, e[32]});
          chk("rdata", f_rvalid ? f_rdata : d_rdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_lock = 1'b0;

    // Reset: requests present but everything forced low.
    step(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1234, 1'b0);
    step(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1234, 1'b0);
    gnt("reset", 1'b0, 1'b0);
    chk("reset_mwe", {31'b0, m_we}, 0);
    chk("reset_locked", {31'b0, locked}, 0);
    chk("reset_rvalid", {30'b0, f_rvalid, d_rvalid}, 0);
    chk("reset_maddr", {22'b0, m_addr}, 0);

    // 1. Fetch only, consecutive addresses.
    for (int unsigned k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, k, 1'b0, 1'b0, 0, 0, 1'b0);
      gnt("fetch", 1'b1, 1'b0);
      chk("fetch_maddr", {22'b0, m_addr}, k);
      push_f(init_word(k));
    end
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("hold_maddr", {22'b0, m_addr}, 2);
    chk("hold_mwe", {31'b0, m_we}, 0);
    idle(1);
    chk("drain_q1", exp_q.size(), 0);

    // 2. Contention after reset: F,D,F,D.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 0, 1'b0);
    gnt("rr0", 1'b1, 1'b0); push_f(init_word(32'h10));
    step(1'b1, 1'b1, 32'h11, 1'b1, 1'b0, 32'h20, 0, 1'b0);
    gnt("rr1", 1'b0, 1'b1); push_d(init_word(32'h20));
    chk("rr1_maddr", {22'b0, m_addr}, 32'h20);
    step(1'b1, 1'b1, 32'h11, 1'b1, 1'b0, 32'h21, 0, 1'b0);
    gnt("rr2", 1'b1, 1'b0); push_f(init_word(32'h11));
    step(1'b1, 1'b1, 32'h12, 1'b1, 1'b0, 32'h21, 0, 1'b0);
    gnt("rr3", 1'b0, 1'b1); push_d(init_word(32'h21));
    idle(2);
    chk("drain_q2", exp_q.size(), 0);

    // 4+3. Fetch granted as lock rises, then load and read back while locked.
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 0, 0, 1'b1);
    gnt("lock_c0", 1'b1, 1'b0); push_f(init_word(32'h5));
    chk("lock_c0_locked", {31'b0, locked}, 0);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 0, 0, 1'b1);
    gnt("drain", 1'b0, 1'b0);
    chk("drain_locked", {31'b0, locked}, 0);
    step(1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 32'h3FF, 32'hDEADBEEF, 1'b1);
    gnt("ld_wr", 1'b0, 1'b1);
    chk("ld_wr_locked", {31'b0, locked}, 1);
    chk("ld_wr_mwe", {31'b0, m_we}, 1);
    chk("ld_wr_maddr", {22'b0, m_addr}, 32'h3FF);
    chk("ld_wr_wdata", m_wdata, 32'hDEADBEEF);
    step(1'b1, 1'b1, 32'h5, 1'b1, 1'b0, 32'h3FF, 0, 1'b1);
    gnt("ld_rd", 1'b0, 1'b1); push_d(32'hDEADBEEF);
    chk("ld_rd_mwe", {31'b0, m_we}, 0);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 0, 0, 1'b1);
    gnt("ld_hold", 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("unlock", 1'b0, 1'b0);
    chk("unlock_locked", {31'b0, locked}, 1);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("resume", 1'b1, 1'b0); push_f(init_word(32'h5));
    chk("resume_locked", {31'b0, locked}, 0);
    idle(2);
    chk("drain_q3", exp_q.size(), 0);

    // Lock dropped during drain returns to NORMAL without locking.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("abort_drain", 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("abort_resume", 1'b1, 1'b0); push_f(init_word(32'h9));
    chk("abort_locked", {31'b0, locked}, 0);

    // 5. Upper address bits are ignored.
    step(1'b1, 1'b1, 32'h0000_0401, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("trunc", 1'b1, 1'b0); push_f(init_word(32'h1));
    chk("trunc_maddr", {22'b0, m_addr}, 32'h001);
    idle(2);
    chk("drain_q5", exp_q.size(), 0);

    // 6. Reset the cycle after a debug read: that read must never return.
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h30, 0, 1'b0);
    gnt("rst_rd", 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h7, 1'b1, 1'b1, 32'h31, 0, 1'b0);
    chk("rst_mid_rvalid", {30'b0, f_rvalid, d_rvalid}, 0);
    gnt("rst_mid", 1'b0, 1'b0);
    chk("rst_mid_mwe", {31'b0, m_we}, 0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("rst_after_maddr", {22'b0, m_addr}, 0);
    chk("rst_after_locked", {31'b0, locked}, 0);
    step(1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 0, 0, 1'b0);
    gnt("rst_resume", 1'b1, 1'b0); push_f(init_word(32'h7));
    idle(3);
    chk("drain_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
